// File: rtl/dm_block_mover_if.sv
// Control and memory-port bundle for the block mover.
// Pure wiring; adds no latency.
// No backpressure: the mover drives the memory every cycle and ignores start while busy.
interface dm_block_mover_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
);

  // Control side
  logic              start;
  logic              mode;      // 0 = FILL, 1 = COPY
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] fill_val;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  count;

  // Memory side (read data is combinational from mem_addr)
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;

  // The mover owns the memory port and reports status back to the controller
  modport master (
    input  start, mode, src, dst, len, fill_val, mem_rd,
    output mem_addr, mem_wd, mem_we, busy, done, count
  );

  // Controller plus memory: supplies requests and read data
  modport slave (
    output start, mode, src, dst, len, fill_val, mem_rd,
    input  mem_addr, mem_wd, mem_we, busy, done, count
  );

endinterface

// File: rtl/dm_block_mover.sv
// Block FILL / COPY engine that owns the data-memory port while busy.
// Latency from start edge to done pulse: FILL len+1, COPY 2*len+1, len=0 gives 1 cycle.
// No backpressure: start is only sampled in IDLE; a start while busy is dropped.
module dm_block_mover #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic             clk,
  input  logic             reset,   // asynchronous, active low
  dm_block_mover_if.master bus
);

  // Largest legal length is the full memory depth; longer requests are clamped to it
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  // Operation context latched at start
  logic              mode_q;
  logic [DATA_W-1:0] fill_q;

  // Walking pointers, progress counters and the one-word copy buffer
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  count_q;
  logic [DATA_W-1:0] buffer;

  // Combinational outputs decoded from the current state
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic              mem_we;
  logic              busy;
  logic              done;

  logic [LEN_W-1:0]  len_clamped;
  logic              last_word;

  assign len_clamped = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;

  // The write in flight is the final one when only one word is left to move
  assign last_word = (remaining == LEN_W'(1));

  // State register; reset drops straight back to IDLE, abandoning any operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and memory/status outputs; everything defaults to an idle port
  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_wd    = '0;
    mem_we    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          if (len_clamped == '0) begin
            state_nxt = DONE;
          end else if (bus.mode) begin
            state_nxt = READ;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      READ: begin
        mem_addr  = src_ptr;
        state_nxt = WRITE;
      end
      WRITE: begin
        mem_addr = dst_ptr;
        mem_we   = 1'b1;
        mem_wd   = mode_q ? buffer : fill_q;
        if (last_word) begin
          state_nxt = DONE;
        end else if (mode_q) begin
          state_nxt = READ;
        end else begin
          state_nxt = WRITE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: latch the request in IDLE, capture read data in READ, advance on each write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= 1'b0;
      fill_q    <= '0;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      count_q   <= '0;
      buffer    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q    <= bus.mode;
            fill_q    <= bus.fill_val;
            src_ptr   <= bus.src;
            dst_ptr   <= bus.dst;
            remaining <= len_clamped;
            count_q   <= '0;
          end
        end
        READ: begin
          // Pointers wrap naturally at the top of the address space
          buffer  <= bus.mem_rd;
          src_ptr <= src_ptr + ADDR_W'(1);
        end
        WRITE: begin
          dst_ptr   <= dst_ptr + ADDR_W'(1);
          remaining <= remaining - LEN_W'(1);
          count_q   <= count_q + LEN_W'(1);
        end
        default: begin
          // DONE: count holds its final value until the next accepted start
        end
      endcase
    end
  end

  assign bus.mem_addr = mem_addr;
  assign bus.mem_wd   = mem_wd;
  assign bus.mem_we   = mem_we;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_dm_block_mover.sv
// Self-checking bench for dm_block_mover: a 32x32 memory model plus a reference of the
// expected memory image and write sequence, computed from the fill/copy rules directly.
// Directed cases from the test plan followed by randomized operations.
module tb_dm_block_mover;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  dm_block_mover_if bus ();

  dm_block_mover dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory attached to the mover, and the reference image of what it should hold
  logic [31:0] mem  [32];
  logic [31:0] refm [32];

  // Backdoor preload port, used only while the mover is idle
  logic        pre_we = 1'b0;
  logic [4:0]  pre_a  = '0;
  logic [31:0] pre_d  = '0;

  // Log of every write the mover performed
  logic [4:0]  wq_a [$];
  logic [31:0] wq_d [$];

  int done_pulses = 0;
  int proto_err   = 0;
  int total       = 0;
  int bad         = 0;

  assign bus.mem_rd = mem[bus.mem_addr];

  // Memory write port and write logger
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wd;
      wq_a.push_back(bus.mem_addr);
      wq_d.push_back(bus.mem_wd);
    end
  end

  // Protocol monitor: count done pulses, flag writes outside a busy non-done cycle
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_pulses++;
    if (bus.mem_we === 1'b1 && (bus.done !== 1'b0 || bus.busy !== 1'b1)) proto_err++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(negedge clk);
    pre_we = 1'b0;
    refm[a] = d;
  endtask

  task automatic mem_check(input string tag);
    int mism;
    mism = 0;
    for (int k = 0; k < 32; k++) begin
      if (mem[k] !== refm[k]) mism++;
    end
    chk(tag, 64'(mism), 64'd0);
  endtask

  // One operation end to end; inj>0 pulses a competing start on that cycle of the operation
  task automatic run_op(input string tag, input logic m, input logic [4:0] s, input logic [4:0] d,
                        input logic [5:0] l, input logic [31:0] fv, input int inj);
    int          L;
    int          base;
    int          dp0;
    int          pe0;
    int          lat;
    int          exp_lat;
    int          nwr;
    logic [4:0]  a;
    logic [31:0] v;
    logic [4:0]  ea [$];
    logic [31:0] ed [$];
    logic        busy_at_done;
    logic [5:0]  cnt_at_done;

    // Reference: ascending word-at-a-time, each copied word read after all earlier writes
    L = (l > 6'd32) ? 32 : int'(l);
    for (int i = 0; i < L; i++) begin
      a = d + 5'(i);
      v = m ? refm[5'(s + 5'(i))] : fv;
      refm[a] = v;
      ea.push_back(a);
      ed.push_back(v);
    end
    exp_lat = (L == 0) ? 1 : (m ? 2 * L + 1 : L + 1);

    @(negedge clk);
    #1;
    base = wq_a.size();
    dp0  = done_pulses;
    pe0  = proto_err;
    bus.start    = 1'b1;
    bus.mode     = m;
    bus.src      = s;
    bus.dst      = d;
    bus.len      = l;
    bus.fill_val = fv;

    lat = 0;
    busy_at_done = 1'b0;
    cnt_at_done  = '0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == inj) begin
        bus.start    = 1'b1;
        bus.mode     = 1'b0;
        bus.dst      = 5'd20;
        bus.len      = 6'd5;
        bus.fill_val = 32'hBAD0BAD0;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        lat          = c;
        busy_at_done = bus.busy;
        cnt_at_done  = bus.count;
        break;
      end
    end
    bus.start = 1'b0;

    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".busy_at_done"}, 64'(busy_at_done), 64'd1);
    chk({tag, ".count_at_done"}, 64'(cnt_at_done), 64'(L));

    @(negedge clk);
    chk({tag, ".busy_after"}, 64'(bus.busy), 64'd0);
    chk({tag, ".count_hold"}, 64'(bus.count), 64'(L));

    repeat (3) @(negedge clk);
    #1;
    chk({tag, ".done_pulses"}, 64'(done_pulses - dp0), 64'd1);
    chk({tag, ".protocol"}, 64'(proto_err - pe0), 64'd0);
    nwr = wq_a.size() - base;
    chk({tag, ".n_writes"}, 64'(nwr), 64'(L));
    for (int i = 0; i < L && i < nwr; i++) begin
      chk($sformatf("%s.write%0d", tag, i), 64'({wq_a[base + i], wq_d[base + i]}),
          64'({ea[i], ed[i]}));
    end
    mem_check({tag, ".mem"});
  endtask

  initial begin
    int         base;
    logic       found;
    logic       m;
    logic [4:0] s;
    logic [4:0] d;
    logic [5:0] l;

    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.src      = '0;
    bus.dst      = '0;
    bus.len      = '0;
    bus.fill_val = '0;

    // Reset state
    #1;
    chk("rst.mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst.mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst.mem_wd", 64'(bus.mem_wd), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.done", 64'(bus.done), 64'd0);
    chk("rst.count", 64'(bus.count), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Random initial memory image
    for (int k = 0; k < 32; k++) poke(5'(k), $urandom);

    // Plain FILL
    run_op("fill", 1'b0, 5'd0, 5'd4, 6'd3, 32'hDEADBEEF, 0);

    // Plain COPY into a disjoint range
    poke(5'd0, 32'h11);
    poke(5'd1, 32'h22);
    poke(5'd2, 32'h33);
    poke(5'd3, 32'h44);
    run_op("copy", 1'b1, 5'd0, 5'd16, 6'd4, 32'h0, 0);

    // Wraparound with clamped length
    run_op("wrap_clamp", 1'b0, 5'd0, 5'd30, 6'd40, 32'hA5, 0);

    // Zero length
    run_op("len0", 1'b0, 5'd0, 5'd9, 6'd0, 32'hFFFF0000, 0);

    // Overlapping forward copy propagates the first word
    poke(5'd0, 32'h7);
    run_op("overlap", 1'b1, 5'd0, 5'd1, 6'd3, 32'h0, 0);

    // Copy onto itself
    run_op("self_copy", 1'b1, 5'd5, 5'd5, 6'd4, 32'h0, 0);

    // Start while busy is ignored
    poke(5'd20, 32'h12345678);
    run_op("busy_start", 1'b0, 5'd0, 5'd0, 6'd8, 32'hC0FFEE00, 3);

    // Reset in the middle of a FILL, during the third write
    @(negedge clk);
    #1;
    base = wq_a.size();
    bus.start    = 1'b1;
    bus.mode     = 1'b0;
    bus.dst      = 5'd8;
    bus.len      = 6'd6;
    bus.fill_val = 32'h55AA55AA;
    found = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.mem_we === 1'b1 && bus.count === 6'd2) begin
        found = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    chk("midrst.reached_third_write", 64'(found), 64'd1);
    reset = 1'b0;
    #1;
    chk("midrst.mem_we", 64'(bus.mem_we), 64'd0);
    chk("midrst.busy", 64'(bus.busy), 64'd0);
    chk("midrst.done", 64'(bus.done), 64'd0);
    chk("midrst.count", 64'(bus.count), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("midrst.idle_after", 64'(bus.busy), 64'd0);
    chk("midrst.n_writes", 64'(wq_a.size() - base), 64'd2);
    refm[8] = 32'h55AA55AA;
    refm[9] = 32'h55AA55AA;
    mem_check("midrst.mem");

    // Randomized operations
    for (int n = 0; n < 20; n++) begin
      m = 1'($urandom_range(0, 1));
      s = 5'($urandom_range(0, 31));
      d = 5'($urandom_range(0, 31));
      l = 6'($urandom_range(0, 40));
      run_op($sformatf("rnd%0d", n), m, s, d, l, $urandom, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
